// File: rtl/eth_pkg.sv
// Shared Ethernet datapath types: packet kinds chosen by the transmit scheduler,
// ARP event codes from eth_recv and the broadcast address.
package eth_pkg;

  typedef enum logic [3:0] {
    PKT_NONE     = 4'd0,
    PKT_ARP_REQ  = 4'd1,
    PKT_ARP_RESP = 4'd2,
    PKT_UDP      = 4'd3
  } pkt_type_e;

  typedef enum logic [1:0] {
    ARP_OP_NONE  = 2'd0,
    ARP_OP_REQ   = 2'd1,
    ARP_OP_REPLY = 2'd2
  } arp_op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_BUSY
  } sched_state_e;

  localparam logic [47:0] BROADCAST_MAC = 48'hFFFF_FFFF_FFFF;

endpackage

// File: rtl/eth_tx_sched_if.sv
// Scheduler bus: ARP events and eth_send strobes in, packet selection out.
// master = surrounding datapath (eth_recv/eth_send), slave = eth_tx_sched.
interface eth_tx_sched_if;
  logic [1:0]  i_arp_op;
  logic [47:0] i_arp_mac;
  logic [31:0] i_arp_ip;
  logic        i_udp_req;
  logic        i_tx_sop;
  logic        i_tx_eop;
  logic [3:0]  o_pkt_type;
  logic [47:0] o_target_mac;
  logic [31:0] o_target_ip;
  logic        o_arp_valid;

  modport master (
    output i_arp_op, i_arp_mac, i_arp_ip, i_udp_req, i_tx_sop, i_tx_eop,
    input  o_pkt_type, o_target_mac, o_target_ip, o_arp_valid
  );

  modport slave (
    input  i_arp_op, i_arp_mac, i_arp_ip, i_udp_req, i_tx_sop, i_tx_eop,
    output o_pkt_type, o_target_mac, o_target_ip, o_arp_valid
  );
endinterface

// File: rtl/eth_ms_tick.sv
// Millisecond prescaler: counts 0..CLK_PER_MS-1 and pulses ms_tick_o for one
// cycle on the wrap.
module eth_ms_tick #(
  parameter int unsigned CLK_PER_MS = 100000
) (
  input  logic clk,
  input  logic rst,
  output logic ms_tick_o
);
  localparam int unsigned CW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;

  logic [CW-1:0] cnt_q;
  logic          wrap;

  assign wrap      = (cnt_q == CW'(CLK_PER_MS - 1));
  assign ms_tick_o = wrap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= wrap ? '0 : cnt_q + 1'b1;
  end
endmodule

// File: rtl/eth_tx_sched.sv
// Transmit scheduler: arbitrates ARP response / ARP request / UDP for eth_send,
// owning the ARP refresh timer, the single-entry target cache and the reply latch.
module eth_tx_sched
  import eth_pkg::*;
#(
  parameter int unsigned CLK_PER_MS    = 100000,
  parameter int unsigned ARP_PERIOD_MS = 3000,
  parameter int unsigned MAX_MISS      = 1,
  parameter logic [31:0] TARGET_IP     = 32'h0A00006F
) (
  input logic           clk,
  input logic           rst,
  eth_tx_sched_if.slave bus
);
  localparam int unsigned TW = (ARP_PERIOD_MS > 1) ? $clog2(ARP_PERIOD_MS) : 1;
  localparam int unsigned MW = (MAX_MISS > 1) ? $clog2(MAX_MISS + 1) : 1;
  localparam logic [MW-1:0] MISS_SAT  = MW'(MAX_MISS);
  localparam logic [MW-1:0] MISS_LAST = MW'(MAX_MISS - 1);

  logic          ms_tick;
  logic [TW-1:0] timer_q;
  logic          req_pend_q, resp_pend_q, arp_valid_q, outstanding_q;
  logic [MW-1:0] miss_q;
  logic [47:0]   lat_mac_q, cache_mac_q, mac_q, mac_d, win_mac;
  logic [31:0]   lat_ip_q, ip_q, ip_d, win_ip;
  pkt_type_e     type_q, type_d, win_type;
  sched_state_e  state_q, state_d;
  logic          arp_req_in, tgt_reply, sop_acc, req_sop, resp_sop, timer_wrap, udp_lost;

  eth_ms_tick #(.CLK_PER_MS(CLK_PER_MS)) u_ms_tick (
    .clk       (clk),
    .rst       (rst),
    .ms_tick_o (ms_tick)
  );

  assign arp_req_in = (bus.i_arp_op == ARP_OP_REQ);
  assign tgt_reply  = (bus.i_arp_op == ARP_OP_REPLY) && (bus.i_arp_ip == TARGET_IP);
  assign sop_acc    = (state_q == S_ARM) && bus.i_tx_sop;
  assign req_sop    = sop_acc && (type_q == PKT_ARP_REQ);
  assign resp_sop   = sop_acc && (type_q == PKT_ARP_RESP);
  assign timer_wrap = ms_tick && (timer_q == TW'(ARP_PERIOD_MS - 1));
  assign udp_lost   = (type_q == PKT_UDP) && !arp_valid_q;

  // A same-cycle target reply wins over miss accounting; the request just sent stays outstanding.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_q       <= '0;
      req_pend_q    <= 1'b1;
      resp_pend_q   <= 1'b0;
      lat_mac_q     <= '0;
      lat_ip_q      <= '0;
      cache_mac_q   <= '0;
      arp_valid_q   <= 1'b0;
      miss_q        <= '0;
      outstanding_q <= 1'b0;
    end else begin
      if (req_sop)      timer_q <= '0;
      else if (ms_tick) timer_q <= timer_wrap ? '0 : timer_q + 1'b1;

      if (timer_wrap)   req_pend_q <= 1'b1;
      else if (req_sop) req_pend_q <= 1'b0;

      if (arp_req_in) begin
        resp_pend_q <= 1'b1;
        lat_mac_q   <= bus.i_arp_mac;
        lat_ip_q    <= bus.i_arp_ip;
      end else if (resp_sop) begin
        resp_pend_q <= 1'b0;
      end

      if (tgt_reply) begin
        cache_mac_q   <= bus.i_arp_mac;
        arp_valid_q   <= 1'b1;
        miss_q        <= '0;
        outstanding_q <= req_sop;
      end else if (req_sop) begin
        outstanding_q <= 1'b1;
        if (outstanding_q) begin
          if (miss_q != MISS_SAT)  miss_q <= miss_q + 1'b1;
          if (miss_q >= MISS_LAST) arp_valid_q <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    win_type = PKT_NONE;
    win_mac  = cache_mac_q;
    win_ip   = TARGET_IP;
    if (resp_pend_q) begin
      win_type = PKT_ARP_RESP;
      win_mac  = lat_mac_q;
      win_ip   = lat_ip_q;
    end else if (req_pend_q) begin
      win_type = PKT_ARP_REQ;
      win_mac  = arp_valid_q ? cache_mac_q : BROADCAST_MAC;
    end else if (arp_valid_q && bus.i_udp_req) begin
      win_type = PKT_UDP;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      type_q  <= PKT_NONE;
      mac_q   <= BROADCAST_MAC;
      ip_q    <= '0;
    end else begin
      state_q <= state_d;
      type_q  <= type_d;
      mac_q   <= mac_d;
      ip_q    <= ip_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (win_type != PKT_NONE) state_d = S_ARM;
      S_ARM: begin
        if (bus.i_tx_sop) state_d = bus.i_tx_eop ? S_IDLE : S_BUSY;
        else if (udp_lost) state_d = S_IDLE;
      end
      S_BUSY:  if (bus.i_tx_eop) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    type_d = type_q;
    mac_d  = mac_q;
    ip_d   = ip_q;
    case (state_q)
      S_IDLE: begin
        type_d = win_type;
        if (win_type != PKT_NONE) begin
          mac_d = win_mac;
          ip_d  = win_ip;
        end
      end
      S_ARM:   if (bus.i_tx_sop ? bus.i_tx_eop : udp_lost) type_d = PKT_NONE;
      S_BUSY:  if (bus.i_tx_eop) type_d = PKT_NONE;
      default: type_d = PKT_NONE;
    endcase
  end

  assign bus.o_pkt_type   = type_q;
  assign bus.o_target_mac = mac_q;
  assign bus.o_target_ip  = ip_q;
  assign bus.o_arp_valid  = arp_valid_q;
endmodule

// File: tb/tb_eth_tx_sched.sv
// Bench for eth_tx_sched: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a behavioural model.
module tb_eth_tx_sched;
  import eth_pkg::*;

  localparam int unsigned CPM  = 10;
  localparam int unsigned PER  = 3;
  localparam int unsigned MAXM = 1;
  localparam logic [31:0] TIP  = 32'h0A00006F;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic cmp_en = 1'b0;
  int   errors = 0;
  int   checks = 0;

  eth_tx_sched_if bus();

  eth_tx_sched #(
    .CLK_PER_MS    (CPM),
    .ARP_PERIOD_MS (PER),
    .MAX_MISS      (MAXM),
    .TARGET_IP     (TIP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int unsigned m_cyc, m_ticks;
  int          m_miss, m_phase;  // phase: 0 nothing offered, 1 offered, 2 frame in flight
  logic        m_req_pend, m_resp_pend, m_out, m_valid;
  logic [47:0] m_lat_mac, m_cache, m_mac;
  logic [31:0] m_lat_ip, m_ip;
  logic [3:0]  m_type;

  task automatic model_reset();
    m_cyc = 0; m_ticks = 0; m_miss = 0; m_phase = 0;
    m_req_pend = 1'b1; m_resp_pend = 1'b0; m_out = 1'b0; m_valid = 1'b0;
    m_lat_mac = '0; m_cache = '0; m_mac = '1; m_lat_ip = '0; m_ip = '0; m_type = 4'd0;
  endtask

  task automatic model_step();
    logic tick, wrap, req_sent, resp_sent, tgt, v_old;
    tick      = (m_cyc % CPM) == CPM - 1;
    wrap      = tick && (m_ticks + 1 == PER);
    req_sent  = (m_phase == 1) && bus.i_tx_sop && (m_type == 4'd1);
    resp_sent = (m_phase == 1) && bus.i_tx_sop && (m_type == 4'd2);
    tgt       = (bus.i_arp_op == 2'd2) && (bus.i_arp_ip == TIP);
    v_old     = m_valid;
    m_cyc++;
    if (req_sent || wrap) m_ticks = 0;
    else if (tick)        m_ticks++;

    if (m_phase == 0) begin
      if (m_resp_pend) begin
        m_type = 4'd2; m_mac = m_lat_mac; m_ip = m_lat_ip; m_phase = 1;
      end else if (m_req_pend) begin
        m_type = 4'd1; m_mac = v_old ? m_cache : 48'hFFFF_FFFF_FFFF; m_ip = TIP; m_phase = 1;
      end else if (v_old && bus.i_udp_req) begin
        m_type = 4'd3; m_mac = m_cache; m_ip = TIP; m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (bus.i_tx_sop) begin
        m_phase = bus.i_tx_eop ? 0 : 2;
        if (bus.i_tx_eop) m_type = 4'd0;
      end else if (m_type == 4'd3 && !v_old) begin
        m_phase = 0; m_type = 4'd0;
      end
    end else if (bus.i_tx_eop) begin
      m_phase = 0; m_type = 4'd0;
    end

    if (wrap) m_req_pend = 1'b1;
    else if (req_sent) m_req_pend = 1'b0;

    if (bus.i_arp_op == 2'd1) begin
      m_resp_pend = 1'b1; m_lat_mac = bus.i_arp_mac; m_lat_ip = bus.i_arp_ip;
    end else if (resp_sent) m_resp_pend = 1'b0;

    if (tgt) begin
      m_cache = bus.i_arp_mac; m_valid = 1'b1; m_miss = 0; m_out = req_sent;
    end else if (req_sent) begin
      if (m_out) begin
        if (m_miss < MAXM) m_miss++;
        if (m_miss >= MAXM) m_valid = 1'b0;
      end
      m_out = 1'b1;
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else     model_step();
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model o_pkt_type", {60'd0, bus.o_pkt_type}, {60'd0, m_type});
      chk("model o_target_mac", {16'd0, bus.o_target_mac}, {16'd0, m_mac});
      chk("model o_target_ip", {32'd0, bus.o_target_ip}, {32'd0, m_ip});
      chk("model o_arp_valid", {63'd0, bus.o_arp_valid}, {63'd0, m_valid});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick_clk();
    @(negedge clk);
    #1;
    bus.i_arp_op = 2'd0;
    bus.i_tx_sop = 1'b0;
    bus.i_tx_eop = 1'b0;
  endtask

  task automatic wait_type(input logic [3:0] t, input int lim, input string name);
    int n = 0;
    while (bus.o_pkt_type !== t && n < lim) begin
      tick_clk();
      n++;
    end
    chk(name, {60'd0, bus.o_pkt_type}, {60'd0, t});
  endtask

  // Acts as eth_send with single-beat frames until type t is offered.
  task automatic serve_until(input logic [3:0] t, input int lim, output int n_udp);
    int n = 0;
    n_udp = 0;
    while (bus.o_pkt_type !== t && n < lim) begin
      if (bus.o_pkt_type !== 4'd0) begin
        if (bus.o_pkt_type === 4'd3) n_udp++;
        bus.i_tx_sop = 1'b1;
        bus.i_tx_eop = 1'b1;
      end
      tick_clk();
      n++;
    end
    chk($sformatf("serve until type %0d", t), {60'd0, bus.o_pkt_type}, {60'd0, t});
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " type"}, {60'd0, bus.o_pkt_type}, 64'd0);
    chk({tag, " mac"}, {16'd0, bus.o_target_mac}, 64'h0000_FFFF_FFFF_FFFF);
    chk({tag, " ip"}, {32'd0, bus.o_target_ip}, 64'd0);
    chk({tag, " valid"}, {63'd0, bus.o_arp_valid}, 64'd0);
  endtask

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog: actual=timeout required=finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    int bad, n3, r;
    logic in_pkt;
    bus.i_arp_op = 2'd0; bus.i_arp_mac = '0; bus.i_arp_ip = '0;
    bus.i_udp_req = 1'b0; bus.i_tx_sop = 1'b0; bus.i_tx_eop = 1'b0;
    #2 rst = 1'b1;
    #1 cmp_en = 1'b1;
    repeat (3) tick_clk();
    chk_reset_vals("reset");
    rst = 1'b0;
    tick_clk();

    wait_type(4'd1, 2, "initial arp_req");
    chk("initial req mac", {16'd0, bus.o_target_mac}, 64'h0000_FFFF_FFFF_FFFF);
    chk("initial req ip", {32'd0, bus.o_target_ip}, 64'h0A00006F);
    bus.i_tx_sop = 1'b1;
    tick_clk();
    repeat (9) tick_clk();
    bus.i_tx_eop = 1'b1;
    tick_clk();
    chk("type after eop", {60'd0, bus.o_pkt_type}, 64'd0);

    bus.i_arp_op = 2'd2; bus.i_arp_mac = 48'hAABB_CCDD_EEFF; bus.i_arp_ip = 32'h0A000007;
    bus.i_udp_req = 1'b1;
    tick_clk();
    bad = 0;
    repeat (5) begin
      if (bus.o_arp_valid !== 1'b0 || bus.o_pkt_type === 4'd3) bad++;
      tick_clk();
    end
    chk("non-target reply ignored", 64'(bad), 64'd0);

    bus.i_arp_op = 2'd2; bus.i_arp_mac = 48'h0011_2233_4455; bus.i_arp_ip = TIP;
    tick_clk();
    chk("valid after target reply", {63'd0, bus.o_arp_valid}, 64'd1);
    wait_type(4'd3, 3, "udp grant");
    chk("udp mac", {16'd0, bus.o_target_mac}, 64'h0000_0011_2233_4455);
    chk("udp ip", {32'd0, bus.o_target_ip}, 64'h0A00006F);

    bus.i_tx_sop = 1'b1;
    tick_clk();
    repeat (20) tick_clk();
    bus.i_arp_op = 2'd1; bus.i_arp_mac = 48'h0200_0000_0005; bus.i_arp_ip = 32'h0A000005;
    tick_clk();
    repeat (19) tick_clk();
    chk("frozen during busy", {60'd0, bus.o_pkt_type}, 64'd3);
    bus.i_tx_eop = 1'b1;
    tick_clk();
    wait_type(4'd2, 3, "arp_resp before arp_req");
    chk("resp ip", {32'd0, bus.o_target_ip}, 64'h0A000005);
    chk("resp mac", {16'd0, bus.o_target_mac}, 64'h0000_0200_0000_0005);
    bus.i_tx_sop = 1'b1; bus.i_tx_eop = 1'b1;
    tick_clk();
    chk("single-beat back to idle", {60'd0, bus.o_pkt_type}, 64'd0);
    wait_type(4'd1, 3, "arp_req after resp");
    chk("unicast refresh mac", {16'd0, bus.o_target_mac}, 64'h0000_0011_2233_4455);
    bus.i_tx_sop = 1'b1; bus.i_tx_eop = 1'b1;
    tick_clk();

    serve_until(4'd1, 100, n3);
    chk("valid before second req", {63'd0, bus.o_arp_valid}, 64'd1);
    bus.i_tx_sop = 1'b1; bus.i_tx_eop = 1'b1;
    tick_clk();
    chk("valid after unanswered req", {63'd0, bus.o_arp_valid}, 64'd0);
    serve_until(4'd1, 100, n3);
    chk("no udp after invalidate", 64'(n3), 64'd0);
    chk("broadcast after invalidate", {16'd0, bus.o_target_mac}, 64'h0000_FFFF_FFFF_FFFF);

    bus.i_tx_sop = 1'b1;
    tick_clk();
    repeat (2) tick_clk();
    rst = 1'b1;
    #1;
    chk_reset_vals("reset mid-busy");
    tick_clk();
    rst = 1'b0;

    in_pkt = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      tick_clk();
      if (rst) begin
        rst = 1'b0;
        continue;
      end
      if ($urandom_range(0, 999) < 2) begin
        rst = 1'b1;
        in_pkt = 1'b0;
        continue;
      end
      if ($urandom_range(0, 99) < 5) bus.i_udp_req = ~bus.i_udp_req;
      r = $urandom_range(0, 99);
      if (r < 4) begin
        bus.i_arp_op  = 2'd1;
        bus.i_arp_mac = {16'h0200, 32'($urandom)};
        bus.i_arp_ip  = {24'h0A0000, 8'($urandom)};
      end else if (r < 9) begin
        bus.i_arp_op  = 2'd2;
        bus.i_arp_mac = {16'h0400, 32'($urandom)};
        bus.i_arp_ip  = ($urandom_range(0, 2) != 0) ? TIP : {24'h0A0000, 8'($urandom_range(1, 100))};
      end
      if (!in_pkt) begin
        if (m_type != 4'd0 && $urandom_range(0, 99) < 35) begin
          bus.i_tx_sop = 1'b1;
          if ($urandom_range(0, 99) < 25) bus.i_tx_eop = 1'b1;
          else in_pkt = 1'b1;
        end else if ($urandom_range(0, 99) < 3) begin
          bus.i_tx_eop = 1'b1;
        end
      end else begin
        if ($urandom_range(0, 99) < 5) bus.i_tx_sop = 1'b1;
        if ($urandom_range(0, 99) < 30) begin
          bus.i_tx_eop = 1'b1;
          in_pkt = 1'b0;
        end
      end
    end
    tick_clk();
    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/eth_tx_sched.md
# eth_tx_sched

Transmit scheduler for the Ethernet datapath: decides which packet `eth_send` builds next (ARP response, ARP request, UDP data) and supplies the destination MAC/IP for it. It sits between `eth_recv` (ARP events) and `eth_send` (sop/eop strobes). It owns the ARP periodic timer, the single-entry ARP cache for the UDP target and the pending-reply latch. It replaces ad-hoc flag logic at the top level with one arbitrated state machine.

## Interface
Parameters:
- CLK_PER_MS, 100000, clk cycles per millisecond tick
- ARP_PERIOD_MS, 3000, interval between ARP requests to the target
- MAX_MISS, 1, unanswered ARP requests tolerated before the cache entry is invalidated
- TARGET_IP, 32'h0A00006F, UDP destination IP (10.0.0.111)

Ports:
- clk  in  1  system clock, 100 MHz
- rst  in  1  asynchronous, active-high reset
- i_arp_op  in  2  from eth_recv, one-cycle strobe: 0 none, 1 ARP request received, 2 ARP reply received
- i_arp_mac  in  48  sender MAC for i_arp_op
- i_arp_ip  in  32  sender IP for i_arp_op
- i_udp_req  in  1  level, UDP payload ready to send
- i_tx_sop  in  1  eth_send start-of-packet strobe
- i_tx_eop  in  1  eth_send end-of-packet strobe
- o_pkt_type  out  4  0 none, 1 ARP_REQ, 2 ARP_RESP, 3 UDP
- o_target_mac  out  48  destination MAC for o_pkt_type
- o_target_ip  out  32  destination IP for o_pkt_type
- o_arp_valid  out  1  ARP cache holds a valid target MAC

## Operation
- ms tick: prescaler counts 0..CLK_PER_MS-1 and pulses `ms_tick` for one cycle at wrap.
- ARP timer: counts ms_tick up to ARP_PERIOD_MS-1. At wrap it sets `req_pend` and restarts. It also restarts on every ARP_REQ sop.
- Reply latch: `i_arp_op==1` stores mac/ip and sets `resp_pend`. A newer request overwrites an unsent one.
- Cache: `i_arp_op==2` with `i_arp_ip==TARGET_IP` stores the MAC, sets o_arp_valid=1 and clears `miss`. Replies from any other IP are ignored. On each ARP_REQ sop, if an earlier request is still unanswered, `miss` increments (saturating). When `miss` reaches MAX_MISS, o_arp_valid is cleared.
- Priority: resp_pend > req_pend > (o_arp_valid && i_udp_req) > none.
- ARP_REQ destination: the cached MAC (unicast refresh) when o_arp_valid=1, otherwise 48'hFFFFFFFFFFFF. The IP is TARGET_IP.
- ARP_RESP destination: latched mac/ip. UDP destination: cached MAC and TARGET_IP.
- FSM:
  - IDLE: evaluate priority. If any source wins, register type/mac/ip and go to ARM. Otherwise hold type 0.
  - ARM: hold the outputs stable. On i_tx_sop, clear the winning pending flag and go to BUSY. If type is UDP and o_arp_valid drops before sop, return to IDLE and set type=0.
  - BUSY: on i_tx_eop, go to IDLE and set o_pkt_type=0. The outputs are frozen during BUSY.
- eth_send samples the type/target only at sop; eth_send never asserts sop while type==0.

## Timing
- Reset values: o_pkt_type=0, o_target_mac=48'hFFFFFFFFFFFF, o_target_ip=0, o_arp_valid=0. Internal: req_pend=1 (ARP request immediately after reset), resp_pend=0, miss=0, FSM=IDLE.
- Latency: a pending source seen in IDLE at cycle N gives registered outputs at N+1 (ARM).
- i_tx_sop and i_tx_eop in the same cycle (single-beat frame) in ARM: go directly to IDLE.
- eop in IDLE/ARM: ignored. sop in IDLE/BUSY: ignored.
- Simultaneous ARP timer wrap and reply from target: cache update wins and miss=0. req_pend is still set.
- Simultaneous i_arp_op==1 and sop of ARP_RESP: the new request is latched and resp_pend stays 1.
- Simultaneous reply and ARP_REQ sop: reply processed, miss=0.
- The cache may be invalidated during BUSY of a UDP frame: the frame completes and no further UDP is granted.
- Reset mid-packet: immediate return to reset values. eth_send is reset by the same rst.

## Structure
- Shared package `eth_pkg`: packet type constants (PKT_NONE/ARP_REQ/ARP_RESP/UDP), ARP op codes, BROADCAST_MAC.
- Sub-module `eth_ms_tick` (prescaler, parameter CLK_PER_MS, output one-cycle ms_tick). It is also reusable by other timers.
- Everything else is in one module with a 3-state FSM.

## Test plan
- After reset release, with CLK_PER_MS=10 and ARP_PERIOD_MS=3: o_pkt_type=1, mac=FFFFFFFFFFFF, ip=0A00006F within 2 cycles. Sop, then eop 10 cycles later: type returns to 0.
- Inject i_arp_op=2 from 10.0.0.111 with MAC 00:11:22:33:44:55, and set i_udp_req=1: o_arp_valid=1, type=3 with that MAC. Periodic ARP_REQ is unicast to 00:11:22:33:44:55 every 30 clk.
- With a valid cache, no further replies and MAX_MISS=1: after the second ARP_REQ sop, o_arp_valid=0, UDP stops, next ARP_REQ goes to broadcast.
- i_arp_op=1 from 10.0.0.5 while an ARP_REQ is pending in IDLE: ARP_RESP (type 2, ip 0A000005) is granted first, then ARP_REQ.
- Single-cycle sop+eop in ARM returns to IDLE in one cycle. Asserting rst mid-BUSY restores all reset values.
- Reply from a non-target IP (10.0.0.7, op 2): o_arp_valid stays 0 and no UDP grant occurs.
